// File: rtl/fp_butterfly_stage.sv
// fp_butterfly_stage
// Radix-2 butterfly stage on complex two's complement fixed-point operands.
// Given operand a and the twiddled product p = w*b, it produces
//   x = a + p and y = a - p
// with optional halving (scale) and either saturation or wrap-around
// (sat). Results are buffered in a 2-entry FIFO with valid/ready
// handshakes on both sides, giving one result per cycle at full rate.
//
// Parameters
//   n      total bit width of every component
//   d      fractional bits (no arithmetic effect, kept for consistency)
//   scale  1: halve both results, 0: full-range results
//   sat    1: clamp out-of-range results, 0: wrap modulo 2^n
//
// Ports
//   clk       rising-edge clock
//   reset     synchronous active-high reset
//   recv_val  upstream operands valid
//   recv_rdy  stage can accept operands (registered)
//   ar, ac    operand a, real / imaginary
//   pr, pc    product p, real / imaginary
//   send_val  result at FIFO head valid
//   send_rdy  downstream accepts result
//   xr, xc    x = a + p, real / imaginary
//   yr, yc    y = a - p, real / imaginary
//   ovf       sticky flag, set once any component saturated or wrapped
module fp_butterfly_stage #(
  parameter int n     = 32,
  parameter int d     = 16,
  parameter int scale = 0,
  parameter int sat   = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         recv_val,
  output logic         recv_rdy,
  input  logic [n-1:0] ar,
  input  logic [n-1:0] ac,
  input  logic [n-1:0] pr,
  input  logic [n-1:0] pc,
  output logic         send_val,
  input  logic         send_rdy,
  output logic [n-1:0] xr,
  output logic [n-1:0] xc,
  output logic [n-1:0] yr,
  output logic [n-1:0] yc,
  output logic         ovf
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam logic [n-1:0] MaxVal = {1'b0, {(n-1){1'b1}}};
  localparam logic [n-1:0] MinVal = {1'b1, {(n-1){1'b0}}};

  // The fractional point never moves through add/subtract, so d only has
  // to be a sensible position inside the word.
  if (d < 0 || d > n) begin : g_bad_frac
    $error("fp_butterfly_stage: d must lie within 0..n");
  end

  // Reduce an n+1-bit sum/difference to n bits. Returns {overflow, value}.
  // With scaling the halved value always fits: dropping the LSB of the
  // n+1-bit word is exactly the sign-filled shift truncated to n bits.
  function automatic logic [n:0] fit(input logic [n:0] full);
    logic         o;
    logic [n-1:0] v;
    o = 1'b0;
    v = full[n-1:0];
    if (scale != 0) begin
      v = full[n:1];
    end else if (full[n] != full[n-1]) begin
      o = 1'b1;
      if (sat != 0) begin
        v = full[n] ? MinVal : MaxVal;
      end
    end
    return {o, v};
  endfunction

  logic [n:0]     sum_r, sum_c, dif_r, dif_c;
  logic [n:0]     fxr, fxc, fyr, fyc;
  logic           any_ovf;
  logic [4*n-1:0] entry;
  logic [4*n-1:0] mem [2];
  logic           head, tail;
  logic           enq, deq;
  state_t         state, next_state;

  // Sign-extend to n+1 bits so neither sum nor difference can lose its sign.
  always_comb begin
    sum_r   = {ar[n-1], ar} + {pr[n-1], pr};
    sum_c   = {ac[n-1], ac} + {pc[n-1], pc};
    dif_r   = {ar[n-1], ar} - {pr[n-1], pr};
    dif_c   = {ac[n-1], ac} - {pc[n-1], pc};
    fxr     = fit(sum_r);
    fxc     = fit(sum_c);
    fyr     = fit(dif_r);
    fyc     = fit(dif_c);
    any_ovf = fxr[n] | fxc[n] | fyr[n] | fyc[n];
    entry   = {fxr[n-1:0], fxc[n-1:0], fyr[n-1:0], fyc[n-1:0]};
  end

  assign send_val = (state != EMPTY);
  assign enq      = recv_val & recv_rdy;
  assign deq      = send_val & send_rdy;
  assign {xr, xc, yr, yc} = mem[head];

  // FIFO occupancy state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EMPTY;
    end else begin
      state <= next_state;
    end
  end

  // Occupancy transitions. FULL never sees an enqueue because recv_rdy is
  // low there.
  always_comb begin
    next_state = state;
    case (state)
      EMPTY:   if (enq) next_state = ONE;
      ONE: begin
        if (enq && !deq)      next_state = FULL;
        else if (!enq && deq) next_state = EMPTY;
      end
      FULL:    if (deq) next_state = ONE;
      default: next_state = EMPTY;
    endcase
  end

  // Storage, pointers, registered ready and the sticky overflow flag.
  // recv_rdy is derived from the next state so it is valid one cycle
  // ahead and still comes straight from a flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem[0]   <= '0;
      mem[1]   <= '0;
      head     <= 1'b0;
      tail     <= 1'b0;
      recv_rdy <= 1'b1;
      ovf      <= 1'b0;
    end else begin
      if (enq) begin
        mem[tail] <= entry;
        tail      <= ~tail;
      end
      if (deq) begin
        head <= ~head;
      end
      if (enq && any_ovf) begin
        ovf <= 1'b1;
      end
      recv_rdy <= (next_state != FULL);
    end
  end

endmodule

// File: tb/tb_fp_butterfly_stage.sv
// Testbench for fp_butterfly_stage.
// Three instances share one stimulus stream: k=0 saturating, k=1 scaled,
// k=2 wrapping. A scoreboard queue receives model results when operands
// are accepted and is popped when the head result is taken downstream.
module tb_fp_butterfly_stage;

  typedef logic [2:0][3:0][31:0] exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        recv_val;
  logic        send_rdy;
  logic [31:0] ar, ac, pr, pc;
  logic        rr [3];
  logic        sv [3];
  logic        ovf_o [3];
  logic [31:0] xr_o [3], xc_o [3], yr_o [3], yc_o [3];

  exp_t        sb [$];
  bit          ovf_exp [3];
  int          compared   = 0;
  int          mismatched = 0;
  bit          prev_stall = 0;
  logic [127:0] prev_out [3];

  always #5 clk = ~clk;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    fp_butterfly_stage #(
      .n(32), .d(16), .scale(k == 1 ? 1 : 0), .sat(k == 2 ? 0 : 1)
    ) u_dut (
      .clk(clk), .reset(reset),
      .recv_val(recv_val), .recv_rdy(rr[k]),
      .ar(ar), .ac(ac), .pr(pr), .pc(pc),
      .send_val(sv[k]), .send_rdy(send_rdy),
      .xr(xr_o[k]), .xc(xc_o[k]), .yr(yr_o[k]), .yc(yc_o[k]),
      .ovf(ovf_o[k])
    );
  end

  // Reference arithmetic in wide signed integers.
  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] p,
                                        input bit sub, input bit sc, input bit st,
                                        output bit o);
    longint ra, rp, r;
    ra = longint'($signed(a));
    rp = longint'($signed(p));
    r  = sub ? ra - rp : ra + rp;
    if (sc) r = r >>> 1;
    o = 1'b0;
    if (r > 64'sd2147483647) begin
      o = 1'b1;
      if (st) r = 64'sd2147483647;
    end else if (r < -64'sd2147483648) begin
      o = 1'b1;
      if (st) r = -64'sd2147483648;
    end
    return r[31:0];
  endfunction

  // Scoreboard monitor: push on accept, pop and compare on take, and hold
  // outputs steady across stalls.
  always @(negedge clk) begin
    exp_t e;
    bit   o0, o1, o2, o3;
    if (reset) begin
      prev_stall = 0;
    end else begin
      if (sv[0] && send_rdy) begin
        if (sb.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL spurious_output got xr=%h with nothing expected", xr_o[0]);
        end else begin
          e = sb.pop_front();
          for (int k = 0; k < 3; k++) begin
            compared++;
            if ({xr_o[k], xc_o[k], yr_o[k], yc_o[k]} !== e[k]) begin
              mismatched++;
              $display("[TB] FAIL result_dut%0d got %h_%h_%h_%h expected %h_%h_%h_%h", k,
                       xr_o[k], xc_o[k], yr_o[k], yc_o[k], e[k][3], e[k][2], e[k][1], e[k][0]);
            end
          end
        end
      end
      if (prev_stall && sv[0]) begin
        for (int k = 0; k < 3; k++) begin
          compared++;
          if ({xr_o[k], xc_o[k], yr_o[k], yc_o[k]} !== prev_out[k]) begin
            mismatched++;
            $display("[TB] FAIL stall_hold_dut%0d got %h expected %h", k,
                     {xr_o[k], xc_o[k], yr_o[k], yc_o[k]}, prev_out[k]);
          end
        end
      end
      prev_stall = sv[0] && !send_rdy;
      for (int k = 0; k < 3; k++) prev_out[k] = {xr_o[k], xc_o[k], yr_o[k], yc_o[k]};
      if (recv_val && rr[0]) begin
        for (int k = 0; k < 3; k++) begin
          e[k][3] = model(ar, pr, 1'b0, k == 1, k != 2, o0);
          e[k][2] = model(ac, pc, 1'b0, k == 1, k != 2, o1);
          e[k][1] = model(ar, pr, 1'b1, k == 1, k != 2, o2);
          e[k][0] = model(ac, pc, 1'b1, k == 1, k != 2, o3);
          if (o0 || o1 || o2 || o3) ovf_exp[k] = 1'b1;
        end
        sb.push_back(e);
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    recv_val = 1'b0;
    sb.delete();
    for (int k = 0; k < 3; k++) ovf_exp[k] = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    ar = 32'h1234_5678; ac = 32'h0; pr = 32'h0; pc = 32'h0;
    send_rdy = 1'b1;
    do_reset();
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      compared += 4;
      if (sv[k] !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_send_val dut%0d got %b expected 0", k, sv[k]); end
      if (rr[k] !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_recv_rdy dut%0d got %b expected 1", k, rr[k]); end
      if (ovf_o[k] !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_ovf dut%0d got %b expected 0", k, ovf_o[k]); end
      if ({xr_o[k], xc_o[k], yr_o[k], yc_o[k]} !== 128'h0) begin
        mismatched++; $display("[TB] FAIL reset_outputs dut%0d got %h expected 0", k, {xr_o[k], xc_o[k], yr_o[k], yc_o[k]});
      end
    end
  endtask

  task automatic test_basic();
    @(posedge clk); #1;
    send_rdy = 1'b1;
    ar = 32'h0001_0000; ac = 32'h0000_8000; pr = 32'h0000_4000; pc = 32'hFFFF_8000;
    recv_val = 1'b1;
    @(posedge clk); #1 recv_val = 1'b0;
    @(negedge clk);
    compared += 3;
    if (sv[0] !== 1'b1) begin mismatched++; $display("[TB] FAIL basic_latency got send_val=%b expected 1", sv[0]); end
    if ({xr_o[0], xc_o[0], yr_o[0], yc_o[0]} !== {32'h0001_4000, 32'h0, 32'h0000_C000, 32'h0001_0000}) begin
      mismatched++; $display("[TB] FAIL basic_value got %h_%h_%h_%h expected 00014000_00000000_0000c000_00010000",
                              xr_o[0], xc_o[0], yr_o[0], yc_o[0]);
    end
    if (ovf_o[0] !== 1'b0) begin mismatched++; $display("[TB] FAIL basic_ovf got %b expected 0", ovf_o[0]); end
    @(negedge clk);
    compared++;
    if (sv[0] !== 1'b0) begin mismatched++; $display("[TB] FAIL basic_drain got send_val=%b expected 0", sv[0]); end
  endtask

  task automatic test_saturate();
    @(posedge clk); #1;
    send_rdy = 1'b1;
    ar = 32'h7FFF_0000; ac = 32'h0; pr = 32'h0002_0000; pc = 32'h0;
    recv_val = 1'b1;
    @(posedge clk); #1 recv_val = 1'b0;
    @(negedge clk);
    compared += 6;
    if (xr_o[0] !== 32'h7FFF_FFFF) begin mismatched++; $display("[TB] FAIL sat_xr got %h expected 7fffffff", xr_o[0]); end
    if (yr_o[0] !== 32'h7FFD_0000) begin mismatched++; $display("[TB] FAIL sat_yr got %h expected 7ffd0000", yr_o[0]); end
    if (xr_o[2] !== 32'h8001_0000) begin mismatched++; $display("[TB] FAIL wrap_xr got %h expected 80010000", xr_o[2]); end
    if (ovf_o[0] !== 1'b1) begin mismatched++; $display("[TB] FAIL sat_ovf got %b expected 1", ovf_o[0]); end
    if (ovf_o[2] !== 1'b1) begin mismatched++; $display("[TB] FAIL wrap_ovf got %b expected 1", ovf_o[2]); end
    if (ovf_o[1] !== 1'b0) begin mismatched++; $display("[TB] FAIL scaled_ovf got %b expected 0", ovf_o[1]); end
    @(posedge clk); #1;
    ar = 32'h8000_0000; pr = 32'h0001_0000;
    recv_val = 1'b1;
    @(posedge clk); #1 recv_val = 1'b0;
    @(negedge clk);
    compared += 2;
    if (yr_o[0] !== 32'h8000_0000) begin mismatched++; $display("[TB] FAIL sat_neg_yr got %h expected 80000000", yr_o[0]); end
    @(posedge clk); #1;
    ar = 32'h0001_0000; pr = 32'h0001_0000;
    recv_val = 1'b1;
    @(posedge clk); #1 recv_val = 1'b0;
    @(negedge clk);
    if (ovf_o[0] !== 1'b1) begin mismatched++; $display("[TB] FAIL sat_ovf_sticky got %b expected 1", ovf_o[0]); end
  endtask

  task automatic test_scale();
    @(posedge clk); #1;
    send_rdy = 1'b1;
    ar = 32'h7FFF_0000; ac = 32'h0; pr = 32'h7FFF_0000; pc = 32'h0;
    recv_val = 1'b1;
    @(posedge clk); #1 recv_val = 1'b0;
    @(negedge clk);
    compared += 3;
    if (xr_o[1] !== 32'h7FFF_0000) begin mismatched++; $display("[TB] FAIL scale_xr got %h expected 7fff0000", xr_o[1]); end
    if (yr_o[1] !== 32'h0) begin mismatched++; $display("[TB] FAIL scale_yr got %h expected 00000000", yr_o[1]); end
    if (ovf_o[1] !== 1'b0) begin mismatched++; $display("[TB] FAIL scale_ovf got %b expected 0", ovf_o[1]); end
  endtask

  task automatic test_backpressure();
    bit accepted;
    int waited;
    do_reset();
    send_rdy = 1'b0;
    ar = 32'h0001_0000; ac = 32'h0002_0000; pr = 32'h0000_1000; pc = 32'hFFFF_0000;
    recv_val = 1'b1;
    @(posedge clk); #1;
    ar = 32'h0003_0000; ac = 32'hFFFE_0000; pr = 32'h0000_2000; pc = 32'h0000_3000;
    @(posedge clk); #1;
    ar = 32'h0005_0000; ac = 32'h0004_0000; pr = 32'h0001_8000; pc = 32'h0000_0001;
    @(negedge clk);
    compared += 2;
    if (rr[0] !== 1'b0) begin mismatched++; $display("[TB] FAIL bp_full_rdy got %b expected 0", rr[0]); end
    if (sv[0] !== 1'b1) begin mismatched++; $display("[TB] FAIL bp_full_val got %b expected 1", sv[0]); end
    repeat (3) begin
      @(negedge clk);
      compared++;
      if (rr[0] !== 1'b0) begin mismatched++; $display("[TB] FAIL bp_hold_rdy got %b expected 0", rr[0]); end
    end
    @(posedge clk); #1 send_rdy = 1'b1;
    accepted = 0;
    waited   = 0;
    while (!accepted && waited < 6) begin
      @(negedge clk);
      if (rr[0]) accepted = 1;
      @(posedge clk); #1;
      waited++;
    end
    recv_val = 1'b0;
    compared++;
    if (!accepted || waited != 2) begin
      mismatched++; $display("[TB] FAIL bp_third_accept got accepted=%0d after %0d cycles expected 1 after 2", accepted, waited);
    end
    repeat (4) @(negedge clk);
    compared++;
    if (sb.size() != 0) begin mismatched++; $display("[TB] FAIL bp_drain got %0d pending expected 0", sb.size()); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    send_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ar = $urandom; ac = $urandom; pr = $urandom; pc = $urandom;
      recv_val = 1'b1;
      @(negedge clk);
      compared++;
      if (rr[0] !== 1'b1) begin mismatched++; $display("[TB] FAIL stream_rdy beat %0d got %b expected 1", i, rr[0]); end
      if (i > 0) begin
        compared++;
        if (sv[0] !== 1'b1) begin mismatched++; $display("[TB] FAIL stream_val beat %0d got %b expected 1", i, sv[0]); end
      end
      @(posedge clk); #1;
    end
    recv_val = 1'b0;
    @(negedge clk);
    compared++;
    if (sv[0] !== 1'b1) begin mismatched++; $display("[TB] FAIL stream_last got %b expected 1", sv[0]); end
    @(negedge clk);
    compared++;
    if (sv[0] !== 1'b0 || sb.size() != 0) begin
      mismatched++; $display("[TB] FAIL stream_drain got send_val=%b pending=%0d expected 0 and 0", sv[0], sb.size());
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    send_rdy = 1'b0;
    ar = 32'h7FFF_0000; ac = 32'h0; pr = 32'h0002_0000; pc = 32'h0;
    recv_val = 1'b1;
    @(posedge clk); #1;
    ar = 32'h0000_1111; ac = 32'h0000_2222; pr = 32'h0000_3333; pc = 32'h0000_4444;
    @(posedge clk); #1 recv_val = 1'b0;
    @(negedge clk);
    compared += 2;
    if (rr[0] !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_full_rdy got %b expected 0", rr[0]); end
    if (ovf_o[0] !== 1'b1) begin mismatched++; $display("[TB] FAIL mid_ovf_set got %b expected 1", ovf_o[0]); end
    @(posedge clk); #1;
    reset = 1'b1;
    recv_val = 1'b1;
    send_rdy = 1'b1;
    sb.delete();
    for (int k = 0; k < 3; k++) ovf_exp[k] = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    recv_val = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      compared += 4;
      if (sv[k] !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_send_val dut%0d got %b expected 0", k, sv[k]); end
      if (rr[k] !== 1'b1) begin mismatched++; $display("[TB] FAIL mid_recv_rdy dut%0d got %b expected 1", k, rr[k]); end
      if (ovf_o[k] !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_ovf dut%0d got %b expected 0", k, ovf_o[k]); end
      if ({xr_o[k], xc_o[k], yr_o[k], yc_o[k]} !== 128'h0) begin
        mismatched++; $display("[TB] FAIL mid_outputs dut%0d got %h expected 0", k, {xr_o[k], xc_o[k], yr_o[k], yc_o[k]});
      end
    end
    repeat (4) begin
      @(negedge clk);
      compared++;
      if (sv[0] !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_stale_emit got send_val=%b expected 0", sv[0]); end
    end
  endtask

  initial begin
    reset    = 1'b1;
    recv_val = 1'b0;
    send_rdy = 1'b0;
    ar = '0; ac = '0; pr = '0; pc = '0;
    $display("[TB] starting fp_butterfly_stage bench");
    test_reset();
    test_basic();
    test_saturate();
    test_scale();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    compared++;
    if (sb.size() != 0) begin mismatched++; $display("[TB] FAIL final_pending got %0d expected 0", sb.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/fp_butterfly_stage.md
FP_BUTTERFLY_STAGE -- requirements
Module: fp_butterfly_stage

Interface
REQ-001 SHALL have parameter n, default 32, total fixed-point bit width (two's complement).
REQ-002 SHALL have parameter d, default 16, fractional bits; carried for consistency, with no arithmetic effect.
REQ-003 SHALL have parameter scale, default 0; 1 means both outputs arithmetic-shift-right by 1 (divide by 2).
REQ-004 SHALL have parameter sat, default 1; 1 means saturate results, 0 means wrap modulo 2^n.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 recv_val  input  1  upstream operands valid.
REQ-008 recv_rdy  output  1  stage can accept operands this cycle.
REQ-009 ar, ac  input  n each  complex operand a, real and imaginary parts.
REQ-010 pr, pc  input  n each  complex product p = w*b from the upstream complex multiplier, real and imaginary parts.
REQ-011 send_val  output  1  result at buffer head valid.
REQ-012 send_rdy  input  1  downstream accepts result.
REQ-013 xr, xc  output  n each  x = a + p, real and imaginary parts.
REQ-014 yr, yc  output  n each  y = a - p, real and imaginary parts.
REQ-015 ovf  output  1  sticky flag: set when any component saturated or wrapped since reset.

Function
REQ-016 A transfer in SHALL occur only in a cycle with recv_val=1 and recv_rdy=1; a transfer out SHALL occur only in a cycle with send_val=1 and send_rdy=1.
REQ-017 Each component SHALL be computed at n+1 bits: sum = a + p, diff = a - p.
REQ-018 When scale=1, the n+1-bit sum/diff SHALL be shifted right by 1 with sign fill before range handling; this case cannot overflow.
REQ-019 When scale=0 and sat=1, out-of-range values SHALL clamp to 2^(n-1)-1 or -2^(n-1); when sat=0, they SHALL truncate to the low n bits.
REQ-020 ovf SHALL set in the cycle after any accepted operand set produces an out-of-range component, and SHALL remain set until reset.
REQ-021 Results SHALL be held in a 2-entry FIFO with states EMPTY, ONE and FULL; outputs SHALL present the head entry.
REQ-022 Latency SHALL be 1 cycle: operands accepted at edge k appear with send_val=1 after edge k.
REQ-023 recv_rdy SHALL be a registered output equal to (state != FULL), giving full throughput of 1 result per cycle while send_rdy=1.
REQ-024 State transitions: EMPTY goes to ONE on enqueue. ONE goes to FULL on enqueue without dequeue, to EMPTY on dequeue without enqueue, and stays ONE on enqueue plus dequeue. FULL goes to ONE on dequeue; enqueue is impossible in FULL.
REQ-025 In ONE with simultaneous enqueue and dequeue, the new result SHALL become head on the next cycle with send_val held at 1.
REQ-026 The FIFO SHALL return results in strict acceptance order.
REQ-027 send_val SHALL equal (state != EMPTY).
REQ-028 While send_val=1 and send_rdy=0, xr/xc/yr/yc SHALL remain stable.
REQ-029 Head/tail pointers SHALL wrap modulo 2.

Reset
REQ-030 On reset=1 at a clock edge, the FIFO SHALL flush to EMPTY, discarding any in-flight data.
REQ-031 On reset=1 at a clock edge, outputs SHALL become send_val=0, recv_rdy=1, ovf=0, and xr=xc=yr=yc=0.
REQ-032 Reset SHALL override a simultaneous transfer in or out.
REQ-033 The first accept after reset deasserts SHALL be possible in the next cycle.

Verification (n=32, d=16, 1.0=0x00010000)
REQ-034 Basic case (scale=0): a=(1.0, 0.5), p=(0.25, -0.5), send_rdy=1 -> one cycle later x=(0x00014000, 0x00000000) and y=(0x0000C000, 0x00010000), ovf=0.
REQ-035 Saturation (sat=1, scale=0): ar=0x7FFF0000, pr=0x00020000 -> xr=0x7FFFFFFF, yr=0x7FFD0000, ovf=1 and remains 1 for the following inputs.
REQ-036 Scaling (scale=1): ar=0x7FFF0000, pr=0x7FFF0000 -> xr=0x7FFF0000 and yr=0, ovf=0.
REQ-037 Backpressure: send_rdy=0 with 3 consecutive offered inputs -> recv_rdy=0 after 2 accepts, outputs stable; raise send_rdy -> results emerge in order, and the third input is accepted once the state leaves FULL.
REQ-038 Streaming: 8 back-to-back inputs with send_rdy=1 -> 8 results on consecutive cycles, recv_rdy never deasserts.
REQ-039 Reset mid-operation: FIFO FULL, assert reset for 1 cycle -> send_val=0, recv_rdy=1, ovf=0, outputs zero, and the previous data is never emitted.
